// File: rtl/residual_analyzer.sv
// residual_analyzer: collects N signed residuals per pass and reports fit
// quality (sum of squared error, peak |e| with its first index, outlier count).
// Results are held with done until ack.
// Optional feature macro: ERR_BIAS_EN builds the signed residual-sum (bias)
// accumulator; without it, bias is tied to zero.
module residual_analyzer #(
  parameter int unsigned    N      = 150,
  parameter int unsigned    W      = 20,
  parameter logic [W-1:0]   THRESH = 20'd4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          e_valid,
  input  logic [W-1:0]  e_in,
  output logic          e_ready,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic [47:0]   sse,
  output logic [W-1:0]  max_abs,
  output logic [7:0]    max_idx,
  output logic [7:0]    outlier_cnt,
  output logic [27:0]   bias
);

  // The square of the most-negative input is 2^(2W-2), which needs one bit
  // more than 2W-2, so the product register is 2W-1 bits to stay exact.
  localparam int unsigned SQW      = 2 * W - 1;
  localparam logic [7:0]  LAST_IDX = 8'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic              v_q;
  logic [W-1:0]      a_q;
  logic [SQW-1:0]    sq_q;
  logic [7:0]        idx_q;
  logic [47:0]       sse_q;
  logic [W-1:0]      max_abs_q;
  logic [7:0]        max_idx_q;
  logic [7:0]        outlier_q;

  logic              xfer;
  logic              start_pass;
  logic [W-1:0]      abs_d;
  logic [SQW-1:0]    sq_d;

  assign xfer       = e_valid & e_ready;
  assign start_pass = (state_q == S_IDLE) & start;

  // |e| as unsigned W bits; the most-negative value maps to 2^(W-1) exactly.
  assign abs_d = e_in[W-1] ? (~e_in + 1'b1) : e_in;
  assign sq_d  = SQW'(abs_d) * SQW'(abs_d);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d = state_q;
    e_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        e_ready = 1'b1;
        busy    = 1'b1;
        if (e_valid && (cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: capture |e|, e^2 and the sample index on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      v_q   <= 1'b0;
      a_q   <= '0;
      sq_q  <= '0;
      idx_q <= '0;
    end else begin
      v_q <= xfer;
      if (xfer) begin
        a_q   <= abs_d;
        sq_q  <= sq_d;
        idx_q <= cnt_q;
        cnt_q <= cnt_q + 8'd1;
      end
      if (start_pass) begin
        cnt_q <= '0;
        v_q   <= 1'b0;
      end
    end
  end

  // Stage 2: fold a valid stage-1 sample into the running statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sse_q     <= '0;
      max_abs_q <= '0;
      max_idx_q <= '0;
      outlier_q <= '0;
    end else if (start_pass) begin
      sse_q     <= '0;
      max_abs_q <= '0;
      max_idx_q <= '0;
      outlier_q <= '0;
    end else if (v_q) begin
      sse_q <= sse_q + 48'(sq_q);
      // Strict compare so a tie keeps the earlier index.
      if (a_q > max_abs_q) begin
        max_abs_q <= a_q;
        max_idx_q <= idx_q;
      end
      if (a_q > THRESH) outlier_q <= outlier_q + 8'd1;
    end
  end

`ifdef ERR_BIAS_EN
  logic [W-1:0]  e_q;
  logic [27:0]   bias_q;

  // Signed residual sum; e is sign-extended to the accumulator width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q    <= '0;
      bias_q <= '0;
    end else begin
      if (xfer) e_q <= e_in;
      if (start_pass)  bias_q <= '0;
      else if (v_q)    bias_q <= bias_q + {{(28 - W){e_q[W-1]}}, e_q};
    end
  end

  assign bias = bias_q;
`else
  assign bias = '0;
`endif

  assign sse         = sse_q;
  assign max_abs     = max_abs_q;
  assign max_idx     = max_idx_q;
  assign outlier_cnt = outlier_q;

endmodule
